sa_tile_sched: RTL

Tile scheduler that sequences the systolic core through a matrix job. Accepts a job descriptor, streams A/W operand vectors from operand memory into the core's input port, waits for the per-column result buffers to fill, then drains results to a downstream valid/ready stream, pulsing the core's output-read strobe per beat. Sits between the host/DMA job queue and the systolic core, one instance per core.

---
 rtl/sa_tile_sched.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/sa_tile_sched.sv
// -----------------------------------------------------------------------------
// sa_tile_sched
//
// This block sequences one systolic core through a matrix job. It accepts a
// job descriptor and then handles each tile in turn. For a tile it streams
// job_k operand vectors from operand memory into the core. It then waits
// until every column result buffer reports valid. Finally it drains ROWS
// result vectors to a downstream stream. When the last tile is drained, the
// block pulses done and returns to IDLE.
//
// Optional feature (macro SA_SCHED_WDT_EN):
//   A stall watchdog counts cycles spent in WAIT_RES, and cycles spent in
//   DRAIN while no result is valid. When the count reaches WDT_CYCLES, the
//   block sets the sticky err flag, pulses done without res_last, and returns
//   to IDLE. Without the macro there is no counter, err is tied to 0, and
//   WAIT_RES waits indefinitely.
//
// Handshakes (job_valid/job_ready and res_valid/res_ready):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   res_valid never depends on res_ready. While res_valid=1 and res_ready=0,
//   res_data holds steady, because the core keeps its buffers until outread.
//   job_valid is only looked at in IDLE. There is no descriptor queueing.
//
// Ports:
//   clk, rstn                 clock (rising edge); async active-low reset
//   job_valid/job_ready       job descriptor handshake
//   job_base, job_k, job_tiles
//                             first operand address, vectors per tile,
//                             tile count
//   mem_rd_en, mem_addr       operand read strobe and address
//   mem_a_data, mem_w_data    read data, valid 1 cycle after mem_rd_en
//   sa_inpvalid, sa_ain, sa_win
//                             core input beat (lane i = [i*INWIDTH +: INWIDTH])
//   sa_rout, sa_rvalid        core result vector, per-column result valid
//   sa_outread                core output-read strobe (one per drained beat)
//   res_valid/res_ready, res_data, res_last
//                             result stream; res_last marks the final beat
//   busy, done, err           not-IDLE flag, completion pulse,
//                             sticky watchdog error
// -----------------------------------------------------------------------------
module sa_tile_sched #(
    parameter int ROWS       = 8,
    parameter int INWIDTH    = 8,
    parameter int OUTWIDTH   = 32,
    parameter int KW         = 16,
    parameter int TW         = 8,
    parameter int AW         = 16,
    parameter int WDT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [AW-1:0]            job_base,
    input  logic [KW-1:0]            job_k,
    input  logic [TW-1:0]            job_tiles,
    output logic                     mem_rd_en,
    output logic [AW-1:0]            mem_addr,
    input  logic [ROWS*INWIDTH-1:0]  mem_a_data,
    input  logic [ROWS*INWIDTH-1:0]  mem_w_data,
    output logic                     sa_inpvalid,
    output logic [ROWS*INWIDTH-1:0]  sa_ain,
    output logic [ROWS*INWIDTH-1:0]  sa_win,
    input  logic [ROWS*OUTWIDTH-1:0] sa_rout,
    input  logic [ROWS-1:0]          sa_rvalid,
    output logic                     sa_outread,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ROWS*OUTWIDTH-1:0] res_data,
    output logic                     res_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int BW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(ROWS - 1);
    localparam logic [KW-1:0] K_ONE     = KW'(1);
    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [AW-1:0] A_ONE     = AW'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        WAIT_RES = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [KW-1:0] k_cnt;
    logic [KW-1:0] k_len;
    logic [TW-1:0] tile_cnt;
    logic [TW-1:0] tile_len;
    logic [BW-1:0] beat_cnt;

    logic all_valid;
    logic last_tile;
    logic last_beat;

    assign all_valid = &sa_rvalid;
    // tile_len is at least 1 whenever a job is active, so the subtraction
    // cannot underflow in any state where the result is used.
    assign last_tile = (tile_cnt == tile_len - T_ONE);
    assign last_beat = (beat_cnt == BEAT_LAST);

    assign job_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign mem_rd_en  = (state == FETCH);
    // mem_addr is gated so that a stale address is not visible between jobs.
    assign mem_addr   = mem_rd_en ? addr : '0;

    // Memory data arrives one cycle after the read. sa_inpvalid is that read
    // strobe delayed by one cycle, so the data already lines up with it.
    assign sa_ain     = sa_inpvalid ? mem_a_data : '0;
    assign sa_win     = sa_inpvalid ? mem_w_data : '0;

    assign res_valid  = (state == DRAIN) & all_valid;
    assign res_data   = res_valid ? sa_rout : '0;
    assign sa_outread = res_valid & res_ready;
    assign res_last   = res_valid & last_tile & last_beat;

`ifdef SA_SCHED_WDT_EN
    localparam int WDW = $clog2(WDT_CYCLES + 1);
    localparam logic [WDW-1:0] WDT_LAST = WDW'(WDT_CYCLES - 1);
    logic [WDW-1:0] wdt_cnt;
    logic           wdt_run;
    assign wdt_run = (state == WAIT_RES) | ((state == DRAIN) & ~res_valid);
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            addr        <= '0;
            k_cnt       <= '0;
            k_len       <= '0;
            tile_cnt    <= '0;
            tile_len    <= '0;
            beat_cnt    <= '0;
            sa_inpvalid <= 1'b0;
            done        <= 1'b0;
`ifdef SA_SCHED_WDT_EN
            wdt_cnt     <= '0;
            err         <= 1'b0;
`endif
        end else begin
            done        <= 1'b0;
            sa_inpvalid <= (state == FETCH);
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        addr     <= job_base;
                        k_len    <= job_k;
                        tile_len <= job_tiles;
                        k_cnt    <= '0;
                        tile_cnt <= '0;
                        beat_cnt <= '0;
                        // An empty job finishes at once: no reads, no core
                        // activity, only the done pulse.
                        if (job_k == '0 || job_tiles == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    // The address keeps counting across tiles and wraps
                    // naturally at 2^AW.
                    addr <= addr + A_ONE;
                    if (k_cnt == k_len - K_ONE) begin
                        k_cnt <= '0;
                        state <= WAIT_RES;
                    end else begin
                        k_cnt <= k_cnt + K_ONE;
                    end
                end
                WAIT_RES: begin
                    if (all_valid) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (sa_outread) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            if (last_tile) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                tile_cnt <= tile_cnt + T_ONE;
                                state    <= FETCH;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef SA_SCHED_WDT_EN
            // The counter measures one continuous stall. When it expires,
            // it overrides whatever the FSM chose above.
            if (wdt_run) begin
                if (wdt_cnt == WDT_LAST) begin
                    wdt_cnt  <= '0;
                    err      <= 1'b1;
                    done     <= 1'b1;
                    beat_cnt <= '0;
                    state    <= IDLE;
                end else begin
                    wdt_cnt <= wdt_cnt + 1'b1;
                end
            end else begin
                wdt_cnt <= '0;
            end
`endif
        end
    end

endmodule
